// File: rtl/apb_multi_slave_mem.sv
// APB4 completer modelling NO_OF_SLAVES independent word memories with programmable wait states,
// byte strobes, error responses and a saturating error counter. Define APB_SLV_PROT_CHECK_EN for pprot checks.
module apb_multi_slave_mem #(
    parameter int                  NO_OF_SLAVES  = 4,
    parameter int                  ADDRESS_WIDTH = 32,
    parameter int                  DATA_WIDTH    = 32,
    parameter int                  MEM_DEPTH     = 64,
    parameter int                  WAIT_W        = 4,
    parameter logic [NO_OF_SLAVES-1:0] SECURE_MASK = '0
) (
    input  logic                       pclk,
    input  logic                       preset_n,
    input  logic [NO_OF_SLAVES-1:0]    pselx,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDRESS_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]      pwdata,
    input  logic [DATA_WIDTH/8-1:0]    pstrb,
    input  logic [2:0]                 pprot,
    input  logic [WAIT_W-1:0]          cfg_wait_states,
    output logic                       pready,
    output logic [DATA_WIDTH-1:0]      prdata,
    output logic                       pslverr,
    output logic [15:0]                err_count
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AL    = $clog2(BYTES);
    localparam int SW    = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int WIDX  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                   state, state_next;
    logic [WAIT_W-1:0]        cnt;
    logic [SW-1:0]            sel_idx;
    logic [WIDX-1:0]          word_idx;
    logic                     err_lat;
    logic                     write_lat;
    logic [DATA_WIDTH-1:0]    mem [NO_OF_SLAVES][MEM_DEPTH];

    logic                     setup;
    logic                     access_ok;
    logic [SW-1:0]            setup_idx;
    logic [ADDRESS_WIDTH-1:0] addr_word;
    logic                     setup_err;
    logic                     complete;
    logic                     resp_err;
    logic                     resp_write;
    logic [SW-1:0]            resp_idx;
    logic [WIDX-1:0]          resp_word;

    assign setup     = (|pselx) && !penable;
    assign access_ok = (|pselx) && penable;
    assign addr_word = paddr >> AL;

    always_comb begin
        setup_idx = '0;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (pselx[i]) setup_idx = SW'(i);
        end
    end

`ifdef APB_SLV_PROT_CHECK_EN
    logic setup_prot_err;
    logic unused_prot;
    // A non-secure access (pprot[1]) to any slave flagged secure is refused.
    assign setup_prot_err = pprot[1] && ((pselx & SECURE_MASK) != '0);
    assign unused_prot    = ^{pprot[2], pprot[0]};
`else
    logic setup_prot_err;
    logic unused_prot;
    assign setup_prot_err = 1'b0;
    assign unused_prot    = ^pprot;
`endif

    assign setup_err = ($countones(pselx) != 1)
                    || ((paddr & ADDRESS_WIDTH'(BYTES - 1)) != '0)
                    || (addr_word >= ADDRESS_WIDTH'(MEM_DEPTH))
                    || setup_prot_err;

    // Zero-wait completions use the live setup decode; waited ones use the latched copy.
    assign complete   = ((state == IDLE) && setup && (cfg_wait_states == '0))
                     || ((state == WAIT) && access_ok && (cnt == WAIT_W'(1)));
    assign resp_err   = (state == IDLE) ? setup_err : err_lat;
    assign resp_write = (state == IDLE) ? pwrite    : write_lat;
    assign resp_idx   = (state == IDLE) ? setup_idx : sel_idx;
    assign resp_word  = (state == IDLE) ? addr_word[WIDX-1:0] : word_idx;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (setup) state_next = (cfg_wait_states == '0) ? DONE : WAIT;
            WAIT: begin
                if (!access_ok)              state_next = IDLE;
                else if (cnt == WAIT_W'(1))  state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_idx   <= '0;
            word_idx  <= '0;
            err_lat   <= 1'b0;
            write_lat <= 1'b0;
            pready    <= 1'b0;
            prdata    <= '0;
            pslverr   <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && setup) begin
                cnt       <= cfg_wait_states;
                sel_idx   <= setup_idx;
                word_idx  <= addr_word[WIDX-1:0];
                err_lat   <= setup_err;
                write_lat <= pwrite;
            end else if ((state == WAIT) && access_ok) begin
                cnt <= cnt - WAIT_W'(1);
            end
            if (complete) begin
                pready  <= 1'b1;
                pslverr <= resp_err;
                if (resp_err) begin
                    prdata <= '0;
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                end else if (!resp_write) begin
                    prdata <= mem[resp_idx][resp_word];
                end
            end else begin
                pready  <= 1'b0;
                pslverr <= 1'b0;
            end
        end
    end

    // Writes commit on the edge that ends the pready cycle, so a reset during the transfer drops them.
    always_ff @(posedge pclk) begin
        if ((state == DONE) && write_lat && !err_lat) begin
            for (int b = 0; b < BYTES; b++) begin
                if (pstrb[b]) mem[sel_idx][word_idx][b*8 +: 8] <= pwdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb_multi_slave_mem.sv
// Directed bench for apb_multi_slave_mem: transaction-level model with a per-cycle compare process.
module tb_apb_multi_slave_mem;

    localparam int NS    = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int WW    = 4;
    localparam logic [NS-1:0] SEC = 4'b0001;

    logic            pclk = 1'b0;
    logic            preset_n = 1'b1;
    logic [NS-1:0]   pselx = '0;
    logic            penable = 1'b0;
    logic            pwrite = 1'b0;
    logic [AW-1:0]   paddr = '0;
    logic [DW-1:0]   pwdata = '0;
    logic [DW/8-1:0] pstrb = '0;
    logic [2:0]      pprot = '0;
    logic [WW-1:0]   cfg_wait_states = '0;
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;
    logic [15:0]     err_count;

    int vectors = 0;
    int miscompares = 0;
    int model_errs = 0;
    logic [DW-1:0] mdl_mem [NS][DEPTH];
    // {err, check_data, data}
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] rd;

    apb_multi_slave_mem #(
        .NO_OF_SLAVES(NS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .MEM_DEPTH(DEPTH), .WAIT_W(WW), .SECURE_MASK(SEC)
    ) dut (
        .pclk(pclk), .preset_n(preset_n), .pselx(pselx), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .cfg_wait_states(cfg_wait_states), .pready(pready),
        .prdata(prdata), .pslverr(pslverr), .err_count(err_count)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic [NS-1:0] sel, input logic [AW-1:0] addr,
                                       input logic [2:0] prot);
        logic e;
        e = ($countones(sel) != 1) || ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
`ifdef APB_SLV_PROT_CHECK_EN
        if (prot[1] && ((sel & SEC) != '0)) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic int slave_of(input logic [NS-1:0] sel);
        int s;
        s = 0;
        for (int i = 0; i < NS; i++) if (sel[i]) s = i;
        return s;
    endfunction

    task automatic apb_xfer(input logic [NS-1:0] sel, input logic [AW-1:0] addr, input logic wr,
                            input logic [DW-1:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                            input int waits, output logic [DW-1:0] rdata);
        logic e;
        int s, w, n;
        logic [DW+1:0] dropped;
        e = model_err(sel, addr, prot);
        s = slave_of(sel);
        w = int'(addr / 4);
        if (e)        exp_q.push_back({1'b1, 1'b1, {DW{1'b0}}});
        else if (!wr) exp_q.push_back({1'b0, 1'b1, mdl_mem[s][w]});
        else          exp_q.push_back({1'b0, 1'b0, {DW{1'b0}}});
        @(posedge pclk); #1;
        pselx = sel; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wdata; pstrb = strb; pprot = prot; cfg_wait_states = WW'(waits);
        @(posedge pclk); #1;
        penable = 1'b1;
        n = 0;
        while (!pready && n < 40) begin
            @(posedge pclk); #1;
            n++;
        end
        check("access_wait_cycles", n, waits);
        if (!pready && exp_q.size() > 0) dropped = exp_q.pop_back();
        rdata = prdata;
        if (wr && !e) begin
            for (int b = 0; b < 4; b++) if (strb[b]) mdl_mem[s][w][b*8 +: 8] = wdata[b*8 +: 8];
        end
    endtask

    // Write with 3 wait states, broken off after one wait cycle by penable drop or reset pulse.
    task automatic apb_abort(input logic use_reset, input logic [NS-1:0] sel, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
        @(posedge pclk); #1;
        pselx = sel; penable = 1'b0; pwrite = 1'b1; paddr = addr;
        pwdata = wdata; pstrb = 4'hF; pprot = 3'b000; cfg_wait_states = WW'(3);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        if (use_reset) begin
            preset_n = 1'b0;
            @(posedge pclk); #1;
            preset_n = 1'b1;
            pselx = '0; penable = 1'b0;
        end else begin
            penable = 1'b0;
            @(posedge pclk); #1;
            pselx = '0;
        end
        repeat (3) @(posedge pclk);
    endtask

    task automatic idle(input int cycles);
        @(posedge pclk); #1;
        pselx = '0; penable = 1'b0;
        repeat (cycles) @(posedge pclk);
    endtask

    always @(negedge pclk) begin
        logic [DW+1:0] e;
        if (!preset_n) begin
            model_errs = 0;
            check("reset_pready", pready, 0);
            check("reset_pslverr", pslverr, 0);
            check("reset_prdata", prdata, 0);
            check("reset_err_count", err_count, 0);
        end else begin
            if (!pready) check("pslverr_without_pready", pslverr, 0);
            if (pready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pready", pready, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pslverr", pslverr, e[DW+1]);
                    if (e[DW]) check("prdata", prdata, e[DW-1:0]);
                    if (e[DW+1] && model_errs < 65535) model_errs++;
                end
            end
            check("err_count", err_count, model_errs);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 preset_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1 preset_n = 1'b1;

        // zero-wait write then read
        apb_xfer(4'b0010, 32'h8, 1'b1, 32'hA5A5_1234, 4'hF, 3'b000, 0, rd);
        apb_xfer(4'b0010, 32'h8, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd);
        check("t1_read_literal", rd, 32'hA5A5_1234);

        // wait states and strobed write
        apb_xfer(4'b0010, 32'h8, 1'b0, 32'h0, 4'h0, 3'b000, 3, rd);
        check("t2_wait3_read_literal", rd, 32'hA5A5_1234);
        apb_xfer(4'b0001, 32'h0, 1'b1, 32'h0000_0000, 4'hF, 3'b000, 2, rd);
        apb_xfer(4'b0001, 32'h0, 1'b1, 32'hFFFF_FFFF, 4'b0100, 3'b000, 1, rd);
        apb_xfer(4'b0001, 32'h0, 1'b0, 32'h0, 4'hF, 3'b000, 0, rd);
        check("t2_strobe_literal", rd, 32'h00FF_0000);

        // error responses
        apb_xfer(4'b0010, 32'h0, 1'b1, 32'h1111_2222, 4'hF, 3'b000, 0, rd);
        apb_xfer(4'b0011, 32'h8, 1'b1, 32'hDEAD_DEAD, 4'hF, 3'b000, 0, rd);
        apb_xfer(4'b0010, 32'h100, 1'b1, 32'hDEAD_DEAD, 4'hF, 3'b000, 1, rd);
        apb_xfer(4'b0010, 32'h2, 1'b1, 32'hCAFE_CAFE, 4'hF, 3'b000, 2, rd);
        check("t3_err_prdata_literal", rd, 32'h0);
        idle(1);
        check("t3_err_count_literal", err_count, 16'd3);
        apb_xfer(4'b0010, 32'h8, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd);
        check("t3_no_write_literal", rd, 32'hA5A5_1234);
        apb_xfer(4'b0010, 32'h0, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd);
        check("t3_unaligned_no_write_literal", rd, 32'h1111_2222);

        // back-to-back writes to every slave at the same address
        for (int i = 0; i < NS; i++)
            apb_xfer(NS'(1 << i), 32'h20, 1'b1, 32'h1000_0000 * (i + 1) + 32'(i), 4'hF, 3'b000, i % 2, rd);
        for (int i = 0; i < NS; i++) begin
            apb_xfer(NS'(1 << i), 32'h20, 1'b0, 32'h0, 4'h0, 3'b000, (i + 1) % 3, rd);
            check("t4_isolation", rd, 32'h1000_0000 * (i + 1) + 32'(i));
        end

        // aborts
        apb_abort(1'b0, 4'b0100, 32'h20, 32'hFFFF_0000);
        apb_xfer(4'b0100, 32'h20, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd);
        check("t5_penable_abort_literal", rd, 32'h3000_0002);
        apb_abort(1'b1, 4'b1000, 32'h20, 32'hFFFF_0000);
        check("t5_err_count_after_reset", err_count, 16'd0);
        apb_xfer(4'b1000, 32'h20, 1'b0, 32'h0, 4'h0, 3'b000, 2, rd);
        check("t5_reset_abort_literal", rd, 32'h4000_0003);

        // protection check
        apb_xfer(4'b0001, 32'h10, 1'b1, 32'h1234_5678, 4'hF, 3'b000, 0, rd);
        apb_xfer(4'b0001, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, 1, rd);
        apb_xfer(4'b0001, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd);
`ifdef APB_SLV_PROT_CHECK_EN
        check("t6_prot_literal", rd, 32'h1234_5678);
`else
        check("t6_prot_literal", rd, 32'hDEAD_BEEF);
`endif
        apb_xfer(4'b0010, 32'h10, 1'b1, 32'h5555_AAAA, 4'hF, 3'b010, 0, rd);
        apb_xfer(4'b0010, 32'h10, 1'b0, 32'h0, 4'h0, 3'b010, 1, rd);
        check("t6_nonsecure_slave_literal", rd, 32'h5555_AAAA);

        idle(3);
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
